uart_tx: RTL
============

# uart_tx

Buffered 8N1 UART transmitter, the transmit-side counterpart of the design's UART receiver, at the same bit timing. Host logic pushes bytes through a valid/ready handshake into a small FIFO. A bit-timing state machine drains the FIFO and serialises each byte onto the TX line, LSB first. Back-to-back frames are sent with no idle gap.

## Interface
- CLKS_PER_BIT, 23: clocks per bit, = f(i_Clock)/baud; must be ≥ 2.
- FIFO_DEPTH, 4: byte buffer depth; power of two, ≥ 2.
- i_Clock  input  1  system clock; all state on rising edge.
- i_Rst_n  input  1  reset, asynchronous assert, active-low.
- i_Tx_DV  input  1  byte valid; accepted on an edge where i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  input  8  byte to send; sampled on accept.
- o_Tx_Ready  output  1  FIFO not full.
- o_Tx_Serial  output  1  serial line, registered; idle high.
- o_Tx_Active  output  1  high while a frame is on the line.
- o_Tx_Done  output  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, FIFO empty, FSM in IDLE, counters 0.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - FIFO non-empty → pop head into shift register, clear counters, drive 0, go to START.
  - Otherwise hold line at 1.
- START: line 0 for CLKS_PER_BIT clocks → DATA, bit index 0.
- DATA:
  - Drive shift[bit index] for CLKS_PER_BIT clocks.
  - Index 0..7 in order, LSB first.
  - After index 7 → PARITY if enabled, else STOP.
- STOP: line 1 for CLKS_PER_BIT clocks.
  - On the last clock, pulse o_Tx_Done.
  - If FIFO non-empty: pop and go straight to START with no idle cycle.
  - Else go to IDLE.
- Clock counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Bit index is 3 bits.
- o_Tx_Active is high from START entry to end of STOP. It stays high across back-to-back frames.
- FIFO:
  - o_Tx_Ready = (count != FIFO_DEPTH), combinational from the registered count.
  - When full, i_Tx_DV is ignored and the byte is dropped, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: line returns to 1 immediately (async), frame aborted, FIFO flushed, no o_Tx_Done.

## Timing
- Latency: byte accepted at edge k into an empty FIFO with FSM idle → o_Tx_Serial falls after edge k+1.
- Frame length: exactly 10·CLKS_PER_BIT clocks, or 11·CLKS_PER_BIT with parity.
- Each bit is held exactly CLKS_PER_BIT clocks. No glitches: the line is driven from a flop.
- o_Tx_Done is high for exactly one cycle per frame, coincident with the final stop-bit clock.
- Throughput: continuous frames whenever the FIFO stays non-empty.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks.
  - Frame becomes 8E1.
- Not defined: no PARITY state or logic. Frame is 8N1, matching the existing receiver.

## Structure
- Shared package uart_pkg: FSM state encodings (IDLE/START/DATA/PARITY/STOP), the frame bit-count constants, and the default CLKS_PER_BIT. Receiver and transmitter use the same package.
- One sub-module: uart_tx_fifo.
  - Synchronous FIFO, width 8, depth FIFO_DEPTH, same clock and async active-low reset.
  - Ports: push, pop, full, empty, data in/out.
- The FSM and shifter live in uart_tx.

## Test plan
1. Single byte: reset, push 0x55 → line 0 for 23 clks, then bits 1,0,1,0,1,0,1,0 at 23 clks each, then stop 1 for 23 clks. o_Tx_Done pulses once, 230 clks after the falling edge; o_Tx_Active falls the next cycle.
2. Back-to-back: push 0x01, 0x80, 0xFF, 0x00 on 4 consecutive cycles → o_Tx_Ready stays 1 (max count 3). 920 contiguous clks of frames with no idle high between stop and start, and 4 o_Tx_Done pulses.
3. Overflow: push 6 bytes on consecutive cycles → byte 1 popped, bytes 2–5 fill the FIFO, o_Tx_Ready=0 on byte 6, which is dropped. Exactly 5 frames are sent.
4. Reset mid-frame: drop i_Rst_n during data bit 3 of 0xA5 → o_Tx_Serial=1 and o_Tx_Active=0 without waiting for a clock edge. No o_Tx_Done; after release, FIFO is empty and the line stays idle.
5. Loopback: o_Tx_Serial drives uart_rx (CLKS_PER_BIT=23), push 0xA5 then 0x3C → receiver reports 0xA5 then 0x3C, one o_Rx_DV each.
6. Parity (UART_TX_PARITY_EN): push 0x07 → parity bit 1; push 0x03 → parity bit 0. Each frame is 253 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// FSM state encodings, frame bit counts and the default bit timing.
package uart_pkg;

    // Default clocks per bit (system clock / baud rate)
    localparam int CLKS_PER_BIT_DEFAULT = 23;

    // Frame geometry
    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS        = 10;
    localparam int FRAME_BITS_PARITY = 11;

    // Bit-timing FSM states; PARITY is only visited in 8E1 builds
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity over a data byte: the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO buffering host writes ahead of the UART
// transmitter. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Occupancy update; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage array; contents need no reset since the count gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: a FIFO accepts host bytes, a bit-timing FSM
// serialises them LSB first with start and stop bits, back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             tx_done;
    logic             bit_end;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_ni  (i_Rst_n),
        .push_i  (i_Tx_DV),
        .pop_i   (fifo_pop),
        .data_i  (i_Tx_Byte),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end     = (cnt_q == CNT_LAST);
    assign o_Tx_Ready  = !fifo_full;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = (state_q != IDLE);
    assign o_Tx_Done   = tx_done;

    // Next-state logic: bit timing, shifter indexing and the registered line value
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        fifo_pop = 1'b0;
        tx_done  = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        serial_d = even_parity(shift_q);
                        state_d  = PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = STOP;
`endif
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    cnt_d   = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_data;
                        idx_d    = '0;
                        serial_d = 1'b0;
                        state_d  = START;
                    end else begin
                        serial_d = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers; reset returns the line high at once and aborts any frame
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

endmodule
